// File: rtl/msg2pkt_ctrl_pkg.sv
// rtl/msg2pkt_ctrl_pkg.sv - shared widths, CTI codes and FSM states for msg2pkt_ctrl
// Contents:
//   MAX_BURST_LENGTH, BUS_*_WIDTH : default geometry of the NIC bus
//   CTI_CLASSIC/CTI_INCR/CTI_EOB  : Wishbone cycle type codes
//   state_t                       : controller FSM states
//   cti_single()                  : true when a first beat is also the last one
package msg2pkt_ctrl_pkg;

   localparam int MAX_BURST_LENGTH  = 8;
   localparam int BUS_DATA_WIDTH    = 32;
   localparam int BUS_ADDRESS_WIDTH = 32;
   localparam int BUS_SEL_WIDTH     = 4;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PKT     = 2'd2
   } state_t;

   // A classic cycle or an end-of-burst marker on the first beat closes the message at once.
   function automatic logic cti_single(input logic [2:0] cti);
      return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
   endfunction

endpackage

// File: rtl/msg2pkt_beat_buf.sv
// rtl/msg2pkt_beat_buf.sv - beat-indexed message buffer with clear, bulk load and single-beat write
// Ports:
//   clk, rst             : clock, synchronous active-high reset (clears buffer)
//   clr                  : zero every beat slot
//   load_en/load_*       : overwrite the whole buffer (reply path)
//   wr_en/wr_idx/wr_*    : write one beat slot (WB path)
//   data_o, sel_o        : buffer contents, beat 0 in the low bits
module msg2pkt_beat_buf #(
   parameter int MAX_BURST = 8,
   parameter int DW        = 32,
   parameter int SW        = 4,
   parameter int IDX_W     = $clog2(MAX_BURST)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    load_en,
   input  logic [MAX_BURST*DW-1:0] load_data,
   input  logic [MAX_BURST*SW-1:0] load_sel,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DW-1:0]           wr_data,
   input  logic [SW-1:0]           wr_sel,
   output logic [MAX_BURST*DW-1:0] data_o,
   output logic [MAX_BURST*SW-1:0] sel_o
);

   logic [MAX_BURST-1:0][DW-1:0] data_q, data_d;
   logic [MAX_BURST-1:0][SW-1:0] sel_q, sel_d;

   // Precedence clear < load < write lets a first beat clear the tail and fill slot 0 together.
   always_comb begin
      data_d = data_q;
      sel_d  = sel_q;
      if (clr) begin
         data_d = '0;
         sel_d  = '0;
      end
      if (load_en) begin
         data_d = load_data;
         sel_d  = load_sel;
      end
      if (wr_en) begin
         data_d[wr_idx] = wr_data;
         sel_d[wr_idx]  = wr_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         sel_q  <= '0;
      end else begin
         data_q <= data_d;
         sel_q  <= sel_d;
      end
   end

   assign data_o = data_q;
   assign sel_o  = sel_q;

endmodule

// File: rtl/msg2pkt_ctrl.sv
// rtl/msg2pkt_ctrl.sv - arbiter/sequencer feeding the msg_to_pkt converter from WB bursts or replies
// Ports:
//   CLK_I, RST_I                       : clock, synchronous active-high reset
//   CYC_I STB_I WE_I ADR_I DAT_I SEL_I CTI_I, ACK_O RTY_O : Wishbone slave (ACK/RTY combinational)
//   rep_valid_i rep_data_i rep_address_i rep_sel_i, rep_ready_o : pre-formed reply input
//   data_o address_o sel_o we_o reply_o : message towards the converter
//   r_msg2pkt_o, pkt_ready_i           : packet valid / taken handshake
module msg2pkt_ctrl
   import msg2pkt_ctrl_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_LENGTH,
   parameter int DW        = BUS_DATA_WIDTH,
   parameter int AW        = BUS_ADDRESS_WIDTH,
   parameter int SW        = BUS_SEL_WIDTH
) (
   input  logic                    CLK_I,
   input  logic                    RST_I,
   input  logic                    CYC_I,
   input  logic                    STB_I,
   input  logic                    WE_I,
   input  logic [AW-1:0]           ADR_I,
   input  logic [DW-1:0]           DAT_I,
   input  logic [SW-1:0]           SEL_I,
   input  logic [2:0]              CTI_I,
   output logic                    ACK_O,
   output logic                    RTY_O,
   input  logic                    rep_valid_i,
   input  logic [MAX_BURST*DW-1:0] rep_data_i,
   input  logic [AW-1:0]           rep_address_i,
   input  logic [MAX_BURST*SW-1:0] rep_sel_i,
   output logic                    rep_ready_o,
   output logic [MAX_BURST*DW-1:0] data_o,
   output logic [AW-1:0]           address_o,
   output logic [MAX_BURST*SW-1:0] sel_o,
   output logic                    we_o,
   output logic                    reply_o,
   output logic                    r_msg2pkt_o,
   input  logic                    pkt_ready_i
);

   localparam int                CNT_W    = $clog2(MAX_BURST);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BURST - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [AW-1:0]     address_q, address_d;
   logic              we_q, we_d;
   logic              reply_q, reply_d;

   logic              wb_req;
   logic              ack, rty, rep_ready;
   logic              buf_clr, buf_load, buf_wr;
   logic [CNT_W-1:0]  buf_idx;

   assign wb_req = CYC_I & STB_I;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      address_d  = address_q;
      we_d       = we_q;
      reply_d    = reply_q;
      ack        = 1'b0;
      rty        = 1'b0;
      rep_ready  = 1'b0;
      buf_clr    = 1'b0;
      buf_load   = 1'b0;
      buf_wr     = 1'b0;
      buf_idx    = beat_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (rep_valid_i) begin
               // Replies win arbitration; a colliding WB cycle is told to retry.
               buf_load  = 1'b1;
               address_d = rep_address_i;
               we_d      = 1'b0;
               reply_d   = 1'b1;
               rep_ready = 1'b1;
               rty       = wb_req;
               state_d   = ST_PKT;
            end else if (wb_req) begin
               ack       = 1'b1;
               buf_clr   = 1'b1;
               buf_wr    = 1'b1;
               buf_idx   = '0;
               address_d = ADR_I;
               we_d      = WE_I;
               reply_d   = 1'b0;
               if (cti_single(CTI_I)) begin
                  state_d = ST_PKT;
               end else begin
                  state_d    = ST_COLLECT;
                  beat_cnt_d = CNT_W'(1);
               end
            end
         end
         ST_COLLECT: begin
            if (!CYC_I) begin
               // Master abandoned the burst: drop the partial message.
               buf_clr    = 1'b1;
               beat_cnt_d = '0;
               state_d    = ST_IDLE;
            end else if (STB_I) begin
               ack        = 1'b1;
               buf_wr     = 1'b1;
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if ((CTI_I == CTI_EOB) || (beat_cnt_q == LAST_IDX)) begin
                  beat_cnt_d = '0;
                  state_d    = ST_PKT;
               end
            end
         end
         ST_PKT: begin
            rty = wb_req;
            if (pkt_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         beat_cnt_q <= '0;
         address_q  <= '0;
         we_q       <= 1'b0;
         reply_q    <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         address_q  <= address_d;
         we_q       <= we_d;
         reply_q    <= reply_d;
      end
   end

   msg2pkt_beat_buf #(
      .MAX_BURST (MAX_BURST),
      .DW        (DW),
      .SW        (SW),
      .IDX_W     (CNT_W)
   ) u_beat_buf (
      .clk       (CLK_I),
      .rst       (RST_I),
      .clr       (buf_clr),
      .load_en   (buf_load),
      .load_data (rep_data_i),
      .load_sel  (rep_sel_i),
      .wr_en     (buf_wr),
      .wr_idx    (buf_idx),
      .wr_data   (DAT_I),
      .wr_sel    (SEL_I),
      .data_o    (data_o),
      .sel_o     (sel_o)
   );

   // Handshakes are suppressed while reset is asserted so nothing is acknowledged that is then lost.
   assign ACK_O       = ack & ~RST_I;
   assign RTY_O       = rty & ~RST_I;
   assign rep_ready_o = rep_ready & ~RST_I;

   assign address_o   = address_q;
   assign we_o        = we_q;
   assign reply_o     = reply_q;
   assign r_msg2pkt_o = (state_q == ST_PKT);

endmodule

// File: tb/tb_msg2pkt_ctrl.sv
// tb/tb_msg2pkt_ctrl.sv - directed and randomized self-checking bench for msg2pkt_ctrl
module tb_msg2pkt_ctrl;
   import msg2pkt_ctrl_pkg::*;

   localparam int NB = 8;

   logic           CLK_I;
   logic           RST_I;
   logic           CYC_I, STB_I, WE_I;
   logic [31:0]    ADR_I, DAT_I;
   logic [3:0]     SEL_I;
   logic [2:0]     CTI_I;
   logic           ACK_O, RTY_O;
   logic           rep_valid_i;
   logic [255:0]   rep_data_i;
   logic [31:0]    rep_address_i;
   logic [31:0]    rep_sel_i;
   logic           rep_ready_o;
   logic [255:0]   data_o;
   logic [31:0]    address_o;
   logic [31:0]    sel_o;
   logic           we_o, reply_o, r_msg2pkt_o;
   logic           pkt_ready_i;

   msg2pkt_ctrl dut (
      .CLK_I         (CLK_I),
      .RST_I         (RST_I),
      .CYC_I         (CYC_I),
      .STB_I         (STB_I),
      .WE_I          (WE_I),
      .ADR_I         (ADR_I),
      .DAT_I         (DAT_I),
      .SEL_I         (SEL_I),
      .CTI_I         (CTI_I),
      .ACK_O         (ACK_O),
      .RTY_O         (RTY_O),
      .rep_valid_i   (rep_valid_i),
      .rep_data_i    (rep_data_i),
      .rep_address_i (rep_address_i),
      .rep_sel_i     (rep_sel_i),
      .rep_ready_o   (rep_ready_o),
      .data_o        (data_o),
      .address_o     (address_o),
      .sel_o         (sel_o),
      .we_o          (we_o),
      .reply_o       (reply_o),
      .r_msg2pkt_o   (r_msg2pkt_o),
      .pkt_ready_i   (pkt_ready_i)
   );

   int checks = 0;
   int failures = 0;

   // Reference message: beats accepted so far, address and direction of the current packet.
   logic [31:0] m_dat[$];
   logic [3:0]  m_sel[$];
   logic [31:0] m_adr;
   logic        m_we;

   initial begin
      CLK_I = 1'b0;
      forever #5 CLK_I = ~CLK_I;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] exp_data();
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < NB; i++)
         if (i < m_dat.size()) v[i*32 +: 32] = m_dat[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_sel();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NB; i++)
         if (i < m_sel.size()) v[i*4 +: 4] = m_sel[i];
      return v;
   endfunction

   task automatic new_msg(input logic [31:0] adr, input logic we);
      m_dat.delete();
      m_sel.delete();
      m_adr = adr;
      m_we  = we;
   endtask

   task automatic bus_idle();
      CYC_I = 1'b0;
      STB_I = 1'b0;
      CTI_I = CTI_CLASSIC;
   endtask

   task automatic wb_beat(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [2:0] cti, input logic we,
                          input logic exp_ack, input logic exp_rty);
      CYC_I = 1'b1;
      STB_I = 1'b1;
      ADR_I = adr;
      DAT_I = dat;
      SEL_I = sel;
      CTI_I = cti;
      WE_I  = we;
      #2;
      chk1({tag, ".ack"}, ACK_O, exp_ack);
      chk1({tag, ".rty"}, RTY_O, exp_rty);
      if (exp_ack) begin
         m_dat.push_back(dat);
         m_sel.push_back(sel);
      end
      tick();
   endtask

   task automatic wb_wait(input string tag);
      CYC_I = 1'b1;
      STB_I = 1'b0;
      #2;
      chk1({tag, ".wait_ack"}, ACK_O, 1'b0);
      chk1({tag, ".wait_rty"}, RTY_O, 1'b0);
      tick();
   endtask

   task automatic chk_pkt(input string tag, input logic exp_reply, input logic chk_we);
      chk1  ({tag, ".valid"}, r_msg2pkt_o, 1'b1);
      chk256({tag, ".data"},  data_o,      exp_data());
      chk32 ({tag, ".sel"},   sel_o,       exp_sel());
      chk32 ({tag, ".addr"},  address_o,   m_adr);
      chk1  ({tag, ".reply"}, reply_o,     exp_reply);
      if (chk_we) chk1({tag, ".we"}, we_o, m_we);
   endtask

   // Packet must be presented now, held for 'hold' idle cycles, then leave after one ready cycle.
   task automatic pkt_wait(input string tag, input int hold, input logic exp_reply, input logic chk_we);
      for (int i = 0; i < hold; i++) begin
         #2;
         chk_pkt(tag, exp_reply, chk_we);
         tick();
      end
      pkt_ready_i = 1'b1;
      #2;
      chk_pkt(tag, exp_reply, chk_we);
      tick();
      pkt_ready_i = 1'b0;
      #2;
      chk1({tag, ".drop"}, r_msg2pkt_o, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk1  ({tag, ".ack"},   ACK_O,       1'b0);
      chk1  ({tag, ".rty"},   RTY_O,       1'b0);
      chk1  ({tag, ".repr"},  rep_ready_o, 1'b0);
      chk1  ({tag, ".valid"}, r_msg2pkt_o, 1'b0);
      chk1  ({tag, ".reply"}, reply_o,     1'b0);
      chk1  ({tag, ".we"},    we_o,        1'b0);
      chk32 ({tag, ".addr"},  address_o,   32'h0);
      chk32 ({tag, ".sel"},   sel_o,       32'h0);
      chk256({tag, ".data"},  data_o,      256'h0);
   endtask

   task automatic setup_reply(input logic [31:0] adr);
      logic [31:0] w;
      logic [3:0]  s;
      new_msg(adr, 1'b0);
      rep_address_i = adr;
      for (int i = 0; i < NB; i++) begin
         w = $urandom;
         s = 4'($urandom);
         rep_data_i[i*32 +: 32] = w;
         rep_sel_i[i*4 +: 4]    = s;
         m_dat.push_back(w);
         m_sel.push_back(s);
      end
   endtask

   initial begin
      int          len, hold;
      logic [2:0]  cti;
      logic [31:0] adr;
      logic        we;

      RST_I = 1'b1;
      bus_idle();
      WE_I = 1'b0; ADR_I = '0; DAT_I = '0; SEL_I = '0;
      rep_valid_i = 1'b0; rep_data_i = '0; rep_address_i = '0; rep_sel_i = '0;
      pkt_ready_i = 1'b0;
      tick();
      tick();
      RST_I = 1'b0;
      #2;
      chk_all_zero("reset");

      // Single classic write.
      new_msg(32'h100, 1'b1);
      wb_beat("single", 32'h100, 32'hA5A5_A5A5, 4'hF, CTI_CLASSIC, 1'b1, 1'b1, 1'b0);
      bus_idle();
      pkt_wait("single", 1, 1'b0, 1'b1);

      // Full 8-beat incrementing burst 1..8, packet held 3 cycles.
      new_msg(32'h2000, 1'b1);
      for (int b = 0; b < NB; b++)
         wb_beat("burst8", 32'h2000, 32'(b + 1), 4'hF, (b == NB - 1) ? CTI_EOB : CTI_INCR, 1'b1, 1'b1, 1'b0);
      bus_idle();
      chk256("burst8.order", data_o, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
      pkt_wait("burst8", 3, 1'b0, 1'b1);

      // Reply and WB request arrive together: reply wins, WB retried then granted.
      setup_reply(32'hCAFE_0000);
      rep_valid_i = 1'b1;
      CYC_I = 1'b1; STB_I = 1'b1; CTI_I = CTI_CLASSIC;
      ADR_I = 32'h300; DAT_I = 32'h1234_5678; SEL_I = 4'h3; WE_I = 1'b1;
      #2;
      chk1("coll.rep_ready", rep_ready_o, 1'b1);
      chk1("coll.rty", RTY_O, 1'b1);
      chk1("coll.ack", ACK_O, 1'b0);
      tick();
      rep_valid_i = 1'b0;
      #2;
      chk1("coll.rep_ready_pulse", rep_ready_o, 1'b0);
      chk1("coll.pkt_rty", RTY_O, 1'b1);
      chk1("coll.pkt_ack", ACK_O, 1'b0);
      chk_pkt("coll.reply", 1'b1, 1'b0);
      pkt_ready_i = 1'b1;
      #1;
      chk1("coll.hs_rty", RTY_O, 1'b1);
      tick();
      pkt_ready_i = 1'b0;
      new_msg(32'h300, 1'b1);
      wb_beat("coll.grant", 32'h300, 32'h1234_5678, 4'h3, CTI_CLASSIC, 1'b1, 1'b1, 1'b0);
      bus_idle();
      pkt_wait("coll.wb", 0, 1'b0, 1'b1);

      // Burst abandoned after 3 beats (with a wait state).
      new_msg(32'h400, 1'b1);
      wb_beat("abort.b0", 32'h400, 32'hDEAD_0001, 4'hF, CTI_INCR, 1'b1, 1'b1, 1'b0);
      wb_wait("abort");
      wb_beat("abort.b1", 32'h400, 32'hDEAD_0002, 4'hF, CTI_INCR, 1'b1, 1'b1, 1'b0);
      wb_beat("abort.b2", 32'h400, 32'hDEAD_0003, 4'hF, CTI_INCR, 1'b1, 1'b1, 1'b0);
      bus_idle();
      tick();
      #2;
      chk1("abort.valid0", r_msg2pkt_o, 1'b0);
      chk256("abort.discard", data_o, 256'h0);
      tick();
      chk1("abort.valid1", r_msg2pkt_o, 1'b0);

      // Ten beats without end-of-burst: beats 9 and 10 are retried.
      new_msg(32'h500, 1'b0);
      for (int b = 0; b < 10; b++)
         wb_beat("long", 32'h500, 32'h5000 + 32'(b), 4'(b), CTI_INCR, 1'b0, b < NB, b >= NB);
      bus_idle();
      pkt_wait("long", 0, 1'b0, 1'b1);

      // Reset during COLLECT at beat 4.
      new_msg(32'h600, 1'b1);
      for (int b = 0; b < 4; b++)
         wb_beat("rstc", 32'h600, $urandom, 4'hF, CTI_INCR, 1'b1, 1'b1, 1'b0);
      RST_I = 1'b1;
      #2;
      chk1("rstc.ack_in_reset", ACK_O, 1'b0);
      tick();
      RST_I = 1'b0;
      bus_idle();
      #2;
      chk_all_zero("rstc");

      // Reset during PKT, together with pkt_ready_i.
      new_msg(32'h700, 1'b1);
      wb_beat("rstp.w", 32'h700, 32'hFFFF_0000, 4'hC, CTI_EOB, 1'b1, 1'b1, 1'b0);
      bus_idle();
      RST_I = 1'b1;
      pkt_ready_i = 1'b1;
      tick();
      RST_I = 1'b0;
      pkt_ready_i = 1'b0;
      #2;
      chk_all_zero("rstp");
      adr = $urandom;
      new_msg(adr, 1'b1);
      wb_beat("rstp.clean", adr, $urandom, 4'h9, CTI_CLASSIC, 1'b1, 1'b1, 1'b0);
      bus_idle();
      pkt_wait("rstp.clean", 1, 1'b0, 1'b1);

      // Randomized mix of bursts and replies.
      for (int it = 0; it < 24; it++) begin
         hold = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            setup_reply($urandom);
            rep_valid_i = 1'b1;
            #2;
            chk1("rnd.rep_ready", rep_ready_o, 1'b1);
            chk1("rnd.rep_ack", ACK_O, 1'b0);
            tick();
            rep_valid_i = 1'b0;
            pkt_wait("rnd.reply", hold, 1'b1, 1'b0);
         end else begin
            len = int'($urandom_range(1, NB));
            adr = $urandom;
            we  = 1'($urandom);
            new_msg(adr, we);
            for (int b = 0; b < len; b++) begin
               if (len == 1)
                  cti = ($urandom % 2 == 0) ? CTI_EOB : CTI_CLASSIC;
               else if (b == len - 1)
                  cti = (len == NB && ($urandom % 2 == 0)) ? CTI_INCR : CTI_EOB;
               else
                  cti = CTI_INCR;
               if (b > 0 && $urandom_range(0, 2) == 0) wb_wait("rnd");
               wb_beat("rnd.beat", adr, $urandom, 4'($urandom), cti, we, 1'b1, 1'b0);
            end
            bus_idle();
            pkt_wait("rnd.burst", hold, 1'b0, 1'b1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
